// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard control: operand forwarding, load-use stall/bubble, multi-cycle MUL/DIV sequencing.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module ex_hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic       if_id_uses_rs2,
  input  logic [4:0] id_ex_rs1,
  input  logic [4:0] id_ex_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_read,
  input  logic       id_ex_multi,
  input  logic       id_ex_is_div,
  input  logic       ex_kill,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_reg_write,
  input  logic [4:0] mem_wb_rd,
  input  logic       mem_wb_reg_write,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b,
  output logic       stall,
  output logic       id_ex_flush,
  output logic       multi_done,
  output logic       busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_multi_stalls
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // The IDLE cycle and the DONE transition each account for one cycle of latency.
  localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 2);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 2);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       lu;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] em_rd, input logic em_we,
                                         input logic [4:0] mw_rd, input logic mw_we);
    if (em_we && em_rd != 5'd0 && em_rd == rs)      fwd_sel = 2'b01;
    else if (mw_we && mw_rd != 5'd0 && mw_rd == rs) fwd_sel = 2'b10;
    else                                            fwd_sel = 2'b00;
  endfunction

  assign forward_a = fwd_sel(id_ex_rs1, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
  assign forward_b = fwd_sel(id_ex_rs2, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);

  assign lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
              ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    stall       = 1'b0;
    id_ex_flush = 1'b0;
    multi_done  = 1'b0;
    case (state)
      IDLE: begin
        if (id_ex_multi && !ex_kill) begin
          stall     = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = id_ex_is_div ? DIV_CNT : MUL_CNT;
        end else begin
          stall       = lu;
          id_ex_flush = lu;
        end
      end
      BUSY: begin
        // ID/EX is frozen here, so a load-use match must not inject a bubble.
        stall = 1'b1;
        if (ex_kill)           state_nxt = IDLE;
        else if (cnt == 8'd0)  state_nxt = DONE;
        else                   cnt_nxt   = cnt - 8'd1;
      end
      DONE: begin
        multi_done  = !ex_kill;
        stall       = lu;
        id_ex_flush = lu;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic multi_stall, lu_stall;

  assign multi_stall = (state == BUSY) || (state == IDLE && id_ex_multi && !ex_kill);
  assign lu_stall    = stall && !multi_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_lu_stalls    <= 32'd0;
      perf_multi_stalls <= 32'd0;
    end else begin
      if (lu_stall)    perf_lu_stalls    <= perf_lu_stalls + 32'd1;
      if (multi_stall) perf_multi_stalls <= perf_multi_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: table of combinational vectors plus multi-cycle sequences.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic       if_id_uses_rs2, id_ex_mem_read, id_ex_multi, id_ex_is_div, ex_kill;
  logic       ex_mem_reg_write, mem_wb_reg_write;
  logic [1:0] forward_a, forward_b;
  logic       stall, id_ex_flush, multi_done, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_stalls, perf_multi_stalls;
`endif

  ex_hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(33)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_multi(id_ex_multi), .id_ex_is_div(id_ex_is_div),
    .ex_kill(ex_kill), .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .id_ex_flush(id_ex_flush), .multi_done(multi_done), .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lu_stalls(perf_lu_stalls), .perf_multi_stalls(perf_multi_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       stall;
    logic       flush;
    logic       mdone;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [4:0] if_rs1, if_rs2;
    logic       uses2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       mem_read;
    logic [4:0] em_rd;
    logic       em_we;
    logic [4:0] mw_rd;
    logic       mw_we;
    string      name;
    exp_t       e;
  } vec_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic exp_t mk(logic [1:0] fa, logic [1:0] fb, logic s, logic f, logic m, logic b);
    exp_t e;
    e.fa = fa; e.fb = fb; e.stall = s; e.flush = f; e.mdone = m; e.busy = b;
    return e;
  endfunction

  task automatic clear_in();
    if_id_rs1 = 0; if_id_rs2 = 0; if_id_uses_rs2 = 0;
    id_ex_rs1 = 0; id_ex_rs2 = 0; id_ex_rd = 0;
    id_ex_mem_read = 0; id_ex_multi = 0; id_ex_is_div = 0; ex_kill = 0;
    ex_mem_rd = 0; ex_mem_reg_write = 0; mem_wb_rd = 0; mem_wb_reg_write = 0;
  endtask

  // Inputs are already driven for this cycle; queue the expectation, compare on the
  // falling edge, then advance to just after the next rising edge.
  task automatic step(input string name, input exp_t e);
    exp_t  x;
    exp_t  got;
    string nm;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
    x  = exp_q.pop_front();
    nm = name_q.pop_front();
    got = mk(forward_a, forward_b, stall, id_ex_flush, multi_done, busy);
    n_vec++;
    if (got !== x) begin
      n_err++;
      $display("FAIL %s: got fa=%b fb=%b stall=%b flush=%b mdone=%b busy=%b, want fa=%b fb=%b stall=%b flush=%b mdone=%b busy=%b",
               nm, got.fa, got.fb, got.stall, got.flush, got.mdone, got.busy,
               x.fa, x.fb, x.stall, x.flush, x.mdone, x.busy);
    end
    @(posedge clk);
    #1;
  endtask

  // Runs a multiply from IDLE to its DONE cycle (4 checked cycles).
  task automatic run_mul(input string tag);
    id_ex_multi = 1; id_ex_is_div = 0;
    step({tag, "_t0"}, mk(0, 0, 1, 0, 0, 0));
    step({tag, "_t1"}, mk(0, 0, 1, 0, 0, 1));
    step({tag, "_t2"}, mk(0, 0, 1, 0, 0, 1));
    step({tag, "_done"}, mk(0, 0, 0, 0, 1, 1));
  endtask

  vec_t vt[10];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{0,0,0, 5,0,0, 0, 5,1, 5,1, "fwd_exmem_prio", mk(2'b01,2'b00,0,0,0,0)};
    vt[1] = '{0,0,0, 0,0,0, 0, 0,1, 0,1, "fwd_rd0",        mk(2'b00,2'b00,0,0,0,0)};
    vt[2] = '{0,0,0, 7,7,0, 0, 0,0, 7,1, "fwd_memwb_both", mk(2'b10,2'b10,0,0,0,0)};
    vt[3] = '{0,0,0, 1,9,0, 0, 9,0, 9,1, "fwd_exmem_nowe", mk(2'b00,2'b10,0,0,0,0)};
    vt[4] = '{0,0,0, 6,4,0, 0, 4,1, 6,1, "fwd_mixed",      mk(2'b10,2'b01,0,0,0,0)};
    vt[5] = '{0,3,1, 0,0,3, 1, 0,0, 0,0, "lu_rs2",         mk(2'b00,2'b00,1,1,0,0)};
    vt[6] = '{0,3,0, 0,0,3, 1, 0,0, 0,0, "lu_rs2_unused",  mk(2'b00,2'b00,0,0,0,0)};
    vt[7] = '{8,0,0, 0,0,8, 1, 0,0, 0,0, "lu_rs1",         mk(2'b00,2'b00,1,1,0,0)};
    vt[8] = '{0,0,1, 0,0,0, 1, 0,0, 0,0, "lu_rd0",         mk(2'b00,2'b00,0,0,0,0)};
    vt[9] = '{8,0,0, 0,0,8, 0, 0,0, 0,0, "no_load",        mk(2'b00,2'b00,0,0,0,0)};

    clear_in();
    reset = 1;
    @(posedge clk);
    #1;
    step("reset_state", mk(0, 0, 0, 0, 0, 0));
    reset = 0;

    foreach (vt[i]) begin
      clear_in();
      if_id_rs1 = vt[i].if_rs1; if_id_rs2 = vt[i].if_rs2; if_id_uses_rs2 = vt[i].uses2;
      id_ex_rs1 = vt[i].ex_rs1; id_ex_rs2 = vt[i].ex_rs2; id_ex_rd = vt[i].ex_rd;
      id_ex_mem_read = vt[i].mem_read;
      ex_mem_rd = vt[i].em_rd; ex_mem_reg_write = vt[i].em_we;
      mem_wb_rd = vt[i].mw_rd; mem_wb_reg_write = vt[i].mw_we;
      step(vt[i].name, vt[i].e);
    end

    // Load-use lasts one cycle once the bubble has gone in.
    clear_in();
    step("lu_cleared", mk(0, 0, 0, 0, 0, 0));

    // MUL, then idle; busy must drop the cycle after DONE.
    run_mul("mul");
    id_ex_multi = 0;
    step("mul_idle", mk(0, 0, 0, 0, 0, 0));

    // Full DIV: 33 stall cycles, then done.
    id_ex_multi = 1; id_ex_is_div = 1;
    step("div_t0", mk(0, 0, 1, 0, 0, 0));
    for (int k = 1; k < 33; k++) step($sformatf("div_t%0d", k), mk(0, 0, 1, 0, 0, 1));
    step("div_done", mk(0, 0, 0, 0, 1, 1));
    id_ex_multi = 0; id_ex_is_div = 0;
    step("div_idle", mk(0, 0, 0, 0, 0, 0));

    // DIV killed at T+5.
    id_ex_multi = 1; id_ex_is_div = 1;
    step("kill_t0", mk(0, 0, 1, 0, 0, 0));
    for (int k = 1; k < 5; k++) step($sformatf("kill_t%0d", k), mk(0, 0, 1, 0, 0, 1));
    ex_kill = 1;
    step("kill_t5", mk(0, 0, 1, 0, 0, 1));
    clear_in();
    for (int k = 6; k < 9; k++) step($sformatf("kill_t%0d", k), mk(0, 0, 0, 0, 0, 0));

    // Reset while a DIV is in BUSY, then a normal MUL.
    id_ex_multi = 1; id_ex_is_div = 1;
    step("rst_div_t0", mk(0, 0, 1, 0, 0, 0));
    step("rst_div_t1", mk(0, 0, 1, 0, 0, 1));
    reset = 1; id_ex_multi = 0; id_ex_is_div = 0;
    step("rst_div_rst", mk(0, 0, 1, 0, 0, 1));
    reset = 0;
    step("rst_div_after", mk(0, 0, 0, 0, 0, 0));
    run_mul("rst_mul");
    id_ex_multi = 0;
    step("rst_mul_idle", mk(0, 0, 0, 0, 0, 0));

    // Load-use during BUSY gives no flush; during DONE it stalls and flushes alongside multi_done.
    id_ex_multi = 1;
    step("lu_mul_t0", mk(0, 0, 1, 0, 0, 0));
    id_ex_mem_read = 1; id_ex_rd = 3; if_id_rs1 = 3;
    step("lu_busy", mk(0, 0, 1, 0, 0, 1));
    step("lu_busy2", mk(0, 0, 1, 0, 0, 1));
    step("lu_done", mk(0, 0, 1, 1, 1, 1));
    clear_in();
    step("lu_done_idle", mk(0, 0, 0, 0, 0, 0));

    // Kill in DONE suppresses multi_done; back-to-back accept after DONE.
    id_ex_multi = 1;
    step("kd_t0", mk(0, 0, 1, 0, 0, 0));
    step("kd_t1", mk(0, 0, 1, 0, 0, 1));
    step("kd_t2", mk(0, 0, 1, 0, 0, 1));
    ex_kill = 1;
    step("kd_done_killed", mk(0, 0, 0, 0, 0, 1));
    ex_kill = 0;
    run_mul("b2b");
    step("b2b_restart", mk(0, 0, 1, 0, 0, 0));
    clear_in();
    reset = 1;
    step("final_rst", mk(0, 0, 1, 0, 0, 1));
    reset = 0;
    step("final_idle", mk(0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
